// File: rtl/cl_axil_write_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite write channel (AW/W/B) between
// N_REQ internal requesters. It carries one single-beat write at a time and
// returns the B response to the owner with a one-cycle done pulse.
module cl_axil_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    input  logic [N_REQ*DATA_W/8-1:0] i_req_strb,
    output logic [N_REQ-1:0]          o_grant,
    output logic [N_REQ-1:0]          o_done,
    output logic [1:0]                o_resp,
    output logic                      o_busy,
    output logic [ADDR_W-1:0]         o_awaddr,
    output logic                      o_awvalid,
    input  logic                      i_awready,
    output logic [DATA_W-1:0]         o_wdata,
    output logic [DATA_W/8-1:0]       o_wstrb,
    output logic                      o_wvalid,
    input  logic                      i_wready,
    input  logic [1:0]                i_bresp,
    input  logic                      i_bvalid,
    output logic                      o_bready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        DONE
    } state_t;

    state_t              state_q;
    logic [N_REQ-1:0]    grant_q;
    logic [IDX_W-1:0]    grantIdx_q;
    logic [N_REQ-1:0]    done_q;
    logic [1:0]          resp_q;
    logic                busy_q;
    logic [ADDR_W-1:0]   awAddr_q;
    logic                awValid_q;
    logic [DATA_W-1:0]   wData_q;
    logic [STRB_W-1:0]   wStrb_q;
    logic                wValid_q;
    logic                bReady_q;
    logic                awDone_q;
    logic                wDone_q;
    logic [IDX_W-1:0]    rrPtr_q;

    logic                pickFound_d;
    logic [IDX_W-1:0]    pickIdx_d;
    logic [IDX_W-1:0]    candIdx;
    logic [N_REQ-1:0]    pickOneHot_d;
    logic [ADDR_W-1:0]   pickAddr_d;
    logic [DATA_W-1:0]   pickData_d;
    logic [STRB_W-1:0]   pickStrb_d;

    logic                awFire;
    logic                wFire;

    // Map pointer + offset back into 0..N_REQ-1; the sum never exceeds 2*N_REQ-2,
    // so a single conditional subtract is enough even for non-power-of-two N_REQ.
    function automatic logic [IDX_W-1:0] wrapIdx(input int v);
        int w;
        w = (v >= N_REQ) ? (v - N_REQ) : v;
        return w[IDX_W-1:0];
    endfunction

    assign awFire = awValid_q & i_awready;
    assign wFire  = wValid_q & i_wready;

    // Round-robin search: first pending requester at or after the pointer, wrapping upward.
    always_comb begin
        pickFound_d = 1'b0;
        pickIdx_d   = '0;
        candIdx     = '0;
        for (int off = 0; off < N_REQ; off++) begin
            candIdx = wrapIdx(int'(rrPtr_q) + off);
            if (!pickFound_d && i_req[candIdx]) begin
                pickFound_d = 1'b1;
                pickIdx_d   = candIdx;
            end
        end
    end

    // Mux the chosen requester's payload and build its one-hot grant.
    always_comb begin
        pickOneHot_d = '0;
        pickAddr_d   = '0;
        pickData_d   = '0;
        pickStrb_d   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pickIdx_d == k[IDX_W-1:0]) begin
                pickOneHot_d[k] = 1'b1;
                pickAddr_d      = i_req_addr[k*ADDR_W +: ADDR_W];
                pickData_d      = i_req_data[k*DATA_W +: DATA_W];
                pickStrb_d      = i_req_strb[k*STRB_W +: STRB_W];
            end
        end
    end

    // Transaction sequencer: grant, independent AW/W handshakes, B capture, done pulse.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grantIdx_q <= '0;
            done_q     <= '0;
            resp_q     <= '0;
            busy_q     <= 1'b0;
            awAddr_q   <= '0;
            awValid_q  <= 1'b0;
            wData_q    <= '0;
            wStrb_q    <= '0;
            wValid_q   <= 1'b0;
            bReady_q   <= 1'b0;
            awDone_q   <= 1'b0;
            wDone_q    <= 1'b0;
            rrPtr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickFound_d) begin
                        grant_q    <= pickOneHot_d;
                        grantIdx_q <= pickIdx_d;
                        awAddr_q   <= pickAddr_d;
                        wData_q    <= pickData_d;
                        wStrb_q    <= pickStrb_d;
                        awValid_q  <= 1'b1;
                        wValid_q   <= 1'b1;
                        awDone_q   <= 1'b0;
                        wDone_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (awFire) begin
                        awValid_q <= 1'b0;
                        awDone_q  <= 1'b1;
                    end
                    if (wFire) begin
                        wValid_q <= 1'b0;
                        wDone_q  <= 1'b1;
                    end
                    if ((awDone_q || awFire) && (wDone_q || wFire)) begin
                        bReady_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    if (i_bvalid && bReady_q) begin
                        resp_q   <= i_bresp;
                        bReady_q <= 1'b0;
                        done_q   <= grant_q;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q   <= '0;
                    grant_q  <= '0;
                    awDone_q <= 1'b0;
                    wDone_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    rrPtr_q  <= wrapIdx(int'(grantIdx_q) + 1);
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_grant   = grant_q;
    assign o_done    = done_q;
    assign o_resp    = resp_q;
    assign o_busy    = busy_q;
    assign o_awaddr  = awAddr_q;
    assign o_awvalid = awValid_q;
    assign o_wdata   = wData_q;
    assign o_wstrb   = wStrb_q;
    assign o_wvalid  = wValid_q;
    assign o_bready  = bReady_q;

endmodule

// File: tb/tb_cl_axil_write_arbiter.sv
// Testbench for cl_axil_write_arbiter: directed scenarios with literal
// expectations, plus a transaction-level model compared every cycle.
module tb_cl_axil_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            i_reset;
    logic [N-1:0]    i_req;
    logic [N*AW-1:0] i_req_addr;
    logic [N*DW-1:0] i_req_data;
    logic [N*SW-1:0] i_req_strb;
    logic [N-1:0]    o_grant;
    logic [N-1:0]    o_done;
    logic [1:0]      o_resp;
    logic            o_busy;
    logic [AW-1:0]   o_awaddr;
    logic            o_awvalid;
    logic            i_awready;
    logic [DW-1:0]   o_wdata;
    logic [SW-1:0]   o_wstrb;
    logic            o_wvalid;
    logic            i_wready;
    logic [1:0]      i_bresp;
    logic            i_bvalid;
    logic            o_bready;

    int checkCount = 0;
    int passCount  = 0;
    bit checkEn    = 1'b0;

    // Transaction-level model state: who owns the channel and which phases remain.
    int            mOwner  = -1;
    int            mRr     = 0;
    bit            mAwv    = 1'b0;
    bit            mWv     = 1'b0;
    bit            mBready = 1'b0;
    bit            mDone   = 1'b0;
    bit            mBusy   = 1'b0;
    logic [AW-1:0] mAddr   = '0;
    logic [DW-1:0] mData   = '0;
    logic [SW-1:0] mStrb   = '0;
    logic [1:0]    mResp   = '0;

    logic [N-1:0]  rrExp [5];

    cl_axil_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_req      (i_req),
        .i_req_addr (i_req_addr),
        .i_req_data (i_req_data),
        .i_req_strb (i_req_strb),
        .o_grant    (o_grant),
        .o_done     (o_done),
        .o_resp     (o_resp),
        .o_busy     (o_busy),
        .o_awaddr   (o_awaddr),
        .o_awvalid  (o_awvalid),
        .i_awready  (i_awready),
        .o_wdata    (o_wdata),
        .o_wstrb    (o_wstrb),
        .o_wvalid   (o_wvalid),
        .i_wready   (i_wready),
        .i_bresp    (i_bresp),
        .i_bvalid   (i_bvalid),
        .o_bready   (o_bready)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic awr, input logic wr,
                                 input logic bv, input logic [1:0] br);
        i_req     = req;
        i_awready = awr;
        i_wready  = wr;
        i_bvalid  = bv;
        i_bresp   = br;
    endtask

    task automatic setPayload(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [SW-1:0] s);
        i_req_addr[k*AW +: AW] = a;
        i_req_data[k*DW +: DW] = d;
        i_req_strb[k*SW +: SW] = s;
    endtask

    task automatic doReset();
        i_reset = 1'b0;
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1);
        i_reset = 1'b1;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (o_busy === 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        checkOutput("idle within budget", 64'(o_busy), 64'h0);
    endtask

    function automatic logic [N-1:0] expGrant();
        logic [N-1:0] g;
        g = '0;
        if (mOwner >= 0) g[mOwner] = 1'b1;
        return g;
    endfunction

    function automatic logic [N-1:0] expDone();
        return mDone ? expGrant() : '0;
    endfunction

    // Model update: one write at a time, owner chosen round-robin, phases retired in order.
    always @(posedge clk) begin
        if (!i_reset) begin
            mOwner = -1; mRr = 0; mAwv = 0; mWv = 0; mBready = 0; mDone = 0; mBusy = 0;
            mAddr = '0; mData = '0; mStrb = '0; mResp = '0;
        end else if (mDone) begin
            mDone  = 0;
            mBusy  = 0;
            mRr    = (mOwner + 1) % N;
            mOwner = -1;
        end else if (mOwner < 0) begin
            for (int off = 0; off < N; off++) begin
                int k;
                k = (mRr + off) % N;
                if (mOwner < 0 && i_req[k]) begin
                    mOwner = k;
                    mAddr  = i_req_addr[k*AW +: AW];
                    mData  = i_req_data[k*DW +: DW];
                    mStrb  = i_req_strb[k*SW +: SW];
                    mAwv   = 1;
                    mWv    = 1;
                    mBusy  = 1;
                end
            end
        end else if (mAwv || mWv) begin
            if (mAwv && i_awready) mAwv = 0;
            if (mWv && i_wready) mWv = 0;
            if (!mAwv && !mWv) mBready = 1;
        end else if (mBready && i_bvalid) begin
            mResp   = i_bresp;
            mBready = 0;
            mDone   = 1;
        end
    end

    // Cycle-by-cycle comparison of every DUT output against the model, mid-cycle.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cmp o_grant",   64'(o_grant),   64'(expGrant()));
            checkOutput("cmp o_done",    64'(o_done),    64'(expDone()));
            checkOutput("cmp o_busy",    64'(o_busy),    64'(mBusy));
            checkOutput("cmp o_awvalid", 64'(o_awvalid), 64'(mAwv));
            checkOutput("cmp o_wvalid",  64'(o_wvalid),  64'(mWv));
            checkOutput("cmp o_bready",  64'(o_bready),  64'(mBready));
            checkOutput("cmp o_awaddr",  64'(o_awaddr),  64'(mAddr));
            checkOutput("cmp o_wdata",   64'(o_wdata),   64'(mData));
            checkOutput("cmp o_wstrb",   64'(o_wstrb),   64'(mStrb));
            if (mDone) checkOutput("cmp o_resp", 64'(o_resp), 64'(mResp));
        end
    end

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        rrExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        i_reset = 1'b0;
        i_req_addr = '0;
        i_req_data = '0;
        i_req_strb = '0;
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 2'b00);
        setPayload(0, 32'h0000_0040, 32'h1111_1111, 4'h1);
        setPayload(1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        setPayload(2, 32'h0000_0200, 32'hCAFE_0002, 4'h3);
        setPayload(3, 32'h0000_0300, 32'h1234_5678, 4'hC);
        step(2);
        checkEn = 1'b1;
        checkOutput("reset o_grant",   64'(o_grant),   64'h0);
        checkOutput("reset o_busy",    64'(o_busy),    64'h0);
        checkOutput("reset o_awvalid", 64'(o_awvalid), 64'h0);
        checkOutput("reset o_awaddr",  64'(o_awaddr),  64'h0);
        i_reset = 1'b1;
        step(1);

        // Single write from requester 1 with an always-ready slave.
        applyStimulus(4'b0010, 1'b1, 1'b1, 1'b1, 2'b00);
        step(1);
        checkOutput("t1 awaddr",  64'(o_awaddr),  64'h100);
        checkOutput("t1 wdata",   64'(o_wdata),   64'hDEAD_BEEF);
        checkOutput("t1 wstrb",   64'(o_wstrb),   64'hF);
        checkOutput("t1 grant",   64'(o_grant),   64'b0010);
        checkOutput("t1 awvalid", 64'(o_awvalid), 64'h1);
        step(1);
        checkOutput("t1 bready",  64'(o_bready),  64'h1);
        step(1);
        checkOutput("t1 done",    64'(o_done),    64'b0010);
        checkOutput("t1 resp",    64'(o_resp),    64'h0);
        applyStimulus('0, 1'b1, 1'b1, 1'b1, 2'b00);
        step(1);
        checkOutput("t1 busy after", 64'(o_busy), 64'h0);

        // Round-robin with all four requesters continuously pending.
        doReset();
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step(1);
            checkOutput("t2 rr grant", 64'(o_grant), 64'(rrExp[i]));
            step(2);
            checkOutput("t2 rr done",  64'(o_done),  64'(rrExp[i]));
            step(1);
        end
        applyStimulus('0, 1'b1, 1'b1, 1'b1, 2'b00);
        waitIdle(20);

        // AW accepted immediately, W stalled until cycle 4.
        doReset();
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1, 2'b00);
        step(1);
        checkOutput("t3 c1 awvalid", 64'(o_awvalid), 64'h1);
        step(1);
        checkOutput("t3 c2 awvalid", 64'(o_awvalid), 64'h0);
        checkOutput("t3 c2 wvalid",  64'(o_wvalid),  64'h1);
        step(1);
        checkOutput("t3 c3 wvalid",  64'(o_wvalid),  64'h1);
        step(1);
        checkOutput("t3 c4 wvalid",  64'(o_wvalid),  64'h1);
        checkOutput("t3 c4 bready",  64'(o_bready),  64'h0);
        applyStimulus(4'b0001, 1'b1, 1'b1, 1'b1, 2'b00);
        step(1);
        checkOutput("t3 c5 bready",  64'(o_bready),  64'h1);
        checkOutput("t3 c5 wvalid",  64'(o_wvalid),  64'h0);
        step(1);
        checkOutput("t3 c6 done",    64'(o_done),    64'b0001);
        applyStimulus('0, 1'b1, 1'b1, 1'b1, 2'b00);
        waitIdle(20);

        // B response stalled six cycles, then SLVERR.
        doReset();
        applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0, 2'b10);
        step(2);
        for (int j = 0; j < 6; j++) begin
            checkOutput("t4 bready held", 64'(o_bready), 64'h1);
            checkOutput("t4 no early done", 64'(o_done), 64'h0);
            if (j == 5) applyStimulus(4'b0100, 1'b1, 1'b1, 1'b1, 2'b10);
            step(1);
        end
        checkOutput("t4 done",  64'(o_done), 64'b0100);
        checkOutput("t4 resp",  64'(o_resp), 64'h2);
        applyStimulus('0, 1'b1, 1'b1, 1'b0, 2'b00);
        step(1);
        checkOutput("t4 done single", 64'(o_done), 64'h0);
        waitIdle(20);

        // Requester 2 drops its request mid-ISSUE; requester 3 goes next.
        doReset();
        applyStimulus(4'b1100, 1'b0, 1'b0, 1'b1, 2'b00);
        step(1);
        checkOutput("t5 grant r2", 64'(o_grant), 64'b0100);
        step(1);
        applyStimulus(4'b1000, 1'b1, 1'b1, 1'b1, 2'b00);
        step(2);
        checkOutput("t5 done r2",  64'(o_done),  64'b0100);
        step(2);
        checkOutput("t5 grant r3", 64'(o_grant), 64'b1000);
        checkOutput("t5 awaddr r3", 64'(o_awaddr), 64'h300);
        applyStimulus('0, 1'b1, 1'b1, 1'b1, 2'b00);
        waitIdle(20);

        // Advance the pointer past 0, then reset while stalled in RESP.
        applyStimulus(4'b0010, 1'b1, 1'b1, 1'b1, 2'b00);
        step(3);
        checkOutput("t6 pre done r1", 64'(o_done), 64'b0010);
        applyStimulus('0, 1'b1, 1'b1, 1'b1, 2'b00);
        step(1);
        applyStimulus(4'b1000, 1'b1, 1'b1, 1'b0, 2'b00);
        step(2);
        checkOutput("t6 in resp", 64'(o_bready), 64'h1);
        i_reset = 1'b0;
        applyStimulus('0, 1'b1, 1'b1, 1'b0, 2'b00);
        step(1);
        checkOutput("t6 rst grant",   64'(o_grant),   64'h0);
        checkOutput("t6 rst done",    64'(o_done),    64'h0);
        checkOutput("t6 rst resp",    64'(o_resp),    64'h0);
        checkOutput("t6 rst busy",    64'(o_busy),    64'h0);
        checkOutput("t6 rst bready",  64'(o_bready),  64'h0);
        checkOutput("t6 rst awvalid", 64'(o_awvalid), 64'h0);
        checkOutput("t6 rst wvalid",  64'(o_wvalid),  64'h0);
        checkOutput("t6 rst awaddr",  64'(o_awaddr),  64'h0);
        checkOutput("t6 rst wdata",   64'(o_wdata),   64'h0);
        checkOutput("t6 rst wstrb",   64'(o_wstrb),   64'h0);
        i_reset = 1'b1;
        applyStimulus(4'b1001, 1'b1, 1'b1, 1'b1, 2'b00);
        step(1);
        checkOutput("t6 grant r0",  64'(o_grant),  64'b0001);
        checkOutput("t6 awaddr r0", 64'(o_awaddr), 64'h40);
        step(2);
        checkOutput("t6 done r0",   64'(o_done),   64'b0001);
        applyStimulus('0, 1'b1, 1'b1, 1'b1, 2'b00);
        waitIdle(20);

        step(2);
        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/cl_axil_write_arbiter.md
# cl_axil_write_arbiter

Round-robin arbiter sharing one AXI4-Lite write channel (AW/W/B) between `N_REQ` internal requesters inside the CL. Each requester presents a single-beat address/data/strobe write and a request line. The arbiter grants one requester at a time, drives the AXI4-Lite master-side write handshakes toward the downstream write slave, and returns the B response to the granted requester with a one-cycle done pulse. It is the sequencing front end for the CL's AXI4-Lite write-request slave logic.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 32: AXI address width.
- `DATA_W`, 32: AXI data width; strobe width is `DATA_W/8`.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `i_reset`  in  1  synchronous, active-low reset.
- `i_req`  in  N_REQ  per-requester write request level; held high until its `o_done` bit.
- `i_req_addr`  in  N_REQ*ADDR_W  flattened addresses; requester k occupies bits [k*ADDR_W +: ADDR_W].
- `i_req_data`  in  N_REQ*DATA_W  flattened write data, same packing.
- `i_req_strb`  in  N_REQ*DATA_W/8  flattened byte strobes.
- `o_grant`  out  N_REQ  one-hot owner of the channel; all-zero when idle.
- `o_done`  out  N_REQ  one-cycle pulse to the granted requester on completion.
- `o_resp`  out  2  BRESP of the completed write; valid only while any `o_done` bit is high.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_awaddr`  out  ADDR_W; `o_awvalid`  out  1; `i_awready`  in  1: AXI write-address channel.
- `o_wdata`  out  DATA_W; `o_wstrb`  out  DATA_W/8; `o_wvalid`  out  1; `i_wready`  in  1: AXI write-data channel.
- `i_bresp`  in  2; `i_bvalid`  in  1; `o_bready`  out  1: AXI write-response channel.

## Operation

- States: IDLE, ISSUE, RESP, DONE. All outputs are registered.
- IDLE: if `i_req` is nonzero, select the first set bit at or after the round-robin pointer `rr_ptr`, searching upward with wrap-around. Latch that requester's addr, data and strb into `o_awaddr`/`o_wdata`/`o_wstrb`. Set `o_grant` one-hot, set `o_awvalid`=`o_wvalid`=1, and go to ISSUE.
- ISSUE:
  - AW and W complete independently. `o_awvalid` drops on the edge after a cycle with `o_awvalid & i_awready`; W behaves the same with `o_wvalid & i_wready`.
  - Internal flags `aw_done` and `w_done` record each completion.
  - When both are done, including both completing in the same cycle, go to RESP and set `o_bready`=1.
  - Address and data registers stay stable while the matching valid is high.
- RESP: on `i_bvalid & o_bready`, capture `i_bresp` into `o_resp`, drop `o_bready`, set `o_done` = `o_grant`, and go to DONE.
- DONE: a single cycle. `o_done` is high during it. On exit, clear `o_done`, `o_grant` and the flags, set `rr_ptr` = (granted index + 1) mod `N_REQ`, and go to IDLE.
- No pipelining: at most one outstanding write; a new grant never occurs in DONE.
- Deasserting `i_req` mid-transaction is ignored. The transaction completes and `o_done` still pulses.
- Requests from non-granted requesters wait; there is no preemption.
- A B response arriving while not in RESP is not accepted, because `o_bready`=0.
- Reset: `i_reset`=0 at a posedge forces IDLE, clears every output (`o_grant`, `o_done`, `o_resp`, `o_busy`, all valids, `o_bready`, addr/data/strb) to 0, and sets `rr_ptr`=0. This applies mid-transaction as well; the abandoned AXI transaction is the system's responsibility.

## Timing

- Request to valid: `i_req` seen at edge N, so `o_awvalid`/`o_wvalid`/`o_grant` are high after edge N (1-cycle latency).
- Best case, with awready, wready and bvalid all high as early as possible:
  - valids high in cycle 1
  - `o_bready` high in cycle 2
  - `o_done` high in cycle 3
  - back to IDLE in cycle 4
  - total: 4 cycles per write, next grant in cycle 5.
- `o_busy` is high from the cycle `o_grant` is set through the DONE cycle inclusive.
- Each ready handshake adds exactly its stall cycles. Neither valid ever drops before its handshake.

## Test plan

- Single write: `i_req`=4'b0010, addr 0x0000_0100, data 0xDEAD_BEEF, strb 0xF, slave always ready, bresp 2'b00 -> `o_awaddr`=0x100 and `o_wdata`=0xDEADBEEF in cycle 1; `o_done`=4'b0010 and `o_resp`=0 in cycle 3.
- Round-robin: all four requests held high -> grants in order 0001, 0010, 0100, 1000, 0001, each preceded by a `o_done` on the prior owner.
- Split handshakes: `i_awready` high at cycle 1, `i_wready` delayed to cycle 4 -> `o_awvalid` low from cycle 2, `o_wvalid` held until cycle 4, `o_bready` rises at cycle 5.
- Response stall and error: `i_bvalid` delayed 6 cycles with bresp 2'b10 -> `o_bready` held high throughout; `o_done` pulses once with `o_resp`=2'b10.
- Request drop: requester 2 deasserts `i_req` during ISSUE -> the write still completes and `o_done[2]` pulses; the next grant goes to requester 3 if it is pending.
- Reset mid-RESP: `i_reset`=0 for one cycle -> all outputs 0 on the next cycle, `rr_ptr`=0; a subsequent `i_req`=4'b1001 grants requester 0.
